mem_port_arbiter: RTL and testbench

//  Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch)
//  and the MEM stage (load/store). Sits between the IAOQ_FRONT/IF_ID fetch path, the EX_MEM-driven

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_wait_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IF   = 2'd1,
    ST_MEM  = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;

  localparam logic       RW_READ  = 1'b0;
  localparam logic       RW_WRITE = 1'b1;

  // Counter width able to hold n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter with a zero flag; tracks the remaining RAM wait states.
module wait_counter #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported RAM between instruction fetch and load/store,
// with MEM priority bounded by a starvation limit for IF.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ack,
  output logic              o_if_stall,
  input  logic              i_mem_req,
  input  logic              i_mem_rw,
  input  logic [1:0]        i_mem_size,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_ack,
  output logic              o_mem_stall,
  output logic              o_ram_en,
  output logic              o_ram_rw,
  output logic [1:0]        o_ram_size,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int CNT_W = cnt_width(WAIT_CYCLES);
  localparam int SC_W  = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] WAIT_LD    = CNT_W'(WAIT_CYCLES);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [SC_W-1:0]   r_starve;
  logic              r_rw;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic w_busy;
  logic w_zero;
  logic w_if_ack;
  logic w_mem_ack;
  logic w_if_abort;
  logic w_arb;
  logic w_starved;
  logic w_grant_if;
  logic w_grant_mem;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_if_abort = (r_state == ST_IF) && i_if_flush;
  assign w_if_ack   = (r_state == ST_IF) && w_zero && !i_if_flush;
  assign w_mem_ack  = (r_state == ST_MEM) && w_zero;
  // An aborted fetch frees the port on the same edge, so it is an arbitration point too.
  assign w_arb      = (r_state == ST_IDLE) || w_if_ack || w_mem_ack || w_if_abort;
  assign w_starved  = (STARVE_LIMIT != 0) && (r_starve == STARVE_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    if (w_arb) begin
      if (!i_if_flush && i_if_req && w_starved) begin
        w_grant_if = 1'b1;
      end else if (i_mem_req) begin
        w_grant_mem = 1'b1;
      end else if (!i_if_flush && i_if_req) begin
        w_grant_if = 1'b1;
      end
      if (w_grant_if) begin
        w_state_nxt = ST_IF;
      end else if (w_grant_mem) begin
        w_state_nxt = ST_MEM;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rw    <= RW_READ;
      r_size  <= SZ_BYTE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant_if) begin
      r_rw    <= RW_READ;
      r_size  <= SZ_WORD;
      r_addr  <= i_if_addr;
      r_wdata <= '0;
    end else if (w_grant_mem) begin
      r_rw    <= i_mem_rw;
      r_size  <= i_mem_size;
      r_addr  <= i_mem_addr;
      r_wdata <= i_mem_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= '0;
    end else if (!i_if_req || w_grant_if) begin
      r_starve <= '0;
    end else if (w_grant_mem && (r_starve != STARVE_MAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  wait_counter #(
    .W (CNT_W)
  ) u_wait_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_grant_if || w_grant_mem),
    .i_load_val (WAIT_LD),
    .i_dec      (w_busy && !w_zero),
    .o_zero     (w_zero)
  );

  assign o_ram_en    = w_busy;
  assign o_ram_rw    = w_busy ? r_rw    : 1'b0;
  assign o_ram_size  = w_busy ? r_size  : 2'b00;
  assign o_ram_addr  = w_busy ? r_addr  : '0;
  assign o_ram_wdata = w_busy ? r_wdata : '0;

  assign o_if_ack    = w_if_ack;
  assign o_mem_ack   = w_mem_ack;
  assign o_if_rdata  = w_if_ack ? i_ram_rdata : '0;
  assign o_mem_rdata = (w_mem_ack && (r_rw == RW_READ)) ? i_ram_rdata : '0;

  // Stalls are qualified by reset so every output reads 0 while reset is held.
  assign o_if_stall  = i_rst_n && i_if_req && !w_if_ack;
  assign o_mem_stall = i_rst_n && i_mem_req && !w_mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with WAIT_CYCLES=1/STARVE_LIMIT=4 and one with WAIT_CYCLES=0.
module tb_mem_port_arbiter;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;

  logic        if_req, if_flush, mem_req, mem_rw;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_ack, if_stall, mem_ack, mem_stall, ram_en, ram_rw;
  logic [1:0]  ram_size;

  logic        b_if_req;
  logic [31:0] b_if_addr;
  logic [31:0] b_if_rdata, b_mem_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic        b_if_ack, b_if_stall, b_mem_ack, b_mem_stall, b_ram_en, b_ram_rw;
  logic [1:0]  b_ram_size;

  int n_vec = 0;
  int n_err = 0;

  assign ram_rdata   = ram_addr ^ K;
  assign b_ram_rdata = b_ram_addr ^ K;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1), .STARVE_LIMIT(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_rdata(if_rdata), .o_if_ack(if_ack), .o_if_stall(if_stall),
    .i_mem_req(mem_req), .i_mem_rw(mem_rw), .i_mem_size(mem_size),
    .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .o_mem_rdata(mem_rdata), .o_mem_ack(mem_ack), .o_mem_stall(mem_stall),
    .o_ram_en(ram_en), .o_ram_rw(ram_rw), .o_ram_size(ram_size),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .STARVE_LIMIT(4)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(b_if_req), .i_if_addr(b_if_addr), .i_if_flush(1'b0),
    .o_if_rdata(b_if_rdata), .o_if_ack(b_if_ack), .o_if_stall(b_if_stall),
    .i_mem_req(1'b0), .i_mem_rw(1'b0), .i_mem_size(2'b00),
    .i_mem_addr(32'h0), .i_mem_wdata(32'h0),
    .o_mem_rdata(b_mem_rdata), .o_mem_ack(b_mem_ack), .o_mem_stall(b_mem_stall),
    .o_ram_en(b_ram_en), .o_ram_rw(b_ram_rw), .o_ram_size(b_ram_size),
    .o_ram_addr(b_ram_addr), .o_ram_wdata(b_ram_wdata), .i_ram_rdata(b_ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_m, n_i, m_before;

    rst_n = 1'b0; if_flush = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b0; mem_rw = 1'b0; mem_size = 2'b00; mem_addr = '0; mem_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0;

    // 1) reset holds every output low, then a single fetch
    #2;
    chk("rst_ram_en",   {31'd0, ram_en},   32'd0);
    chk("rst_if_ack",   {31'd0, if_ack},   32'd0);
    chk("rst_if_stall", {31'd0, if_stall}, 32'd0);
    chk("rst_ram_addr", ram_addr,          32'd0);
    chk("rst_if_rdata", if_rdata,          32'd0);
    chk("rst_b_ram_en", {31'd0, b_ram_en}, 32'd0);
    cyc(); rst_n = 1'b1; #1;
    chk("t1_c0_ram_en",   {31'd0, ram_en},   32'd0);
    chk("t1_c0_if_stall", {31'd0, if_stall}, 32'd1);
    cyc();
    chk("t1_c1_ram_en",   {31'd0, ram_en},   32'd1);
    chk("t1_c1_if_ack",   {31'd0, if_ack},   32'd0);
    chk("t1_c1_ram_addr", ram_addr,          32'h100);
    chk("t1_c1_ram_size", {30'd0, ram_size}, 32'd2);
    cyc();
    chk("t1_c2_ram_en",   {31'd0, ram_en},   32'd1);
    chk("t1_c2_if_ack",   {31'd0, if_ack},   32'd1);
    chk("t1_c2_if_rdata", if_rdata,          32'h100 ^ K);
    chk("t1_c2_if_stall", {31'd0, if_stall}, 32'd0);
    if_req = 1'b0;
    cyc();
    chk("t1_c3_ram_en",   {31'd0, ram_en},   32'd0);
    chk("t1_c3_if_rdata", if_rdata,          32'd0);

    // 2) simultaneous requests: MEM first, IF back-to-back
    if_req = 1'b1; if_addr = 32'h200;
    mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEADBEEF; mem_size = 2'b10;
    cyc();
    chk("t2_ram_rw",     {31'd0, ram_rw},    32'd1);
    chk("t2_ram_addr",   ram_addr,           32'h40);
    chk("t2_ram_wdata",  ram_wdata,          32'hDEADBEEF);
    chk("t2_ram_size",   {30'd0, ram_size},  32'd2);
    chk("t2_mem_ack0",   {31'd0, mem_ack},   32'd0);
    chk("t2_mem_stall",  {31'd0, mem_stall}, 32'd1);
    chk("t2_if_stall",   {31'd0, if_stall},  32'd1);
    cyc();
    chk("t2_mem_ack1",   {31'd0, mem_ack},   32'd1);
    chk("t2_mem_rdata",  mem_rdata,          32'd0);
    chk("t2_if_ack_w",   {31'd0, if_ack},    32'd0);
    mem_req = 1'b0;
    cyc();
    chk("t2_if_b2b_en",  {31'd0, ram_en},    32'd1);
    chk("t2_if_rw",      {31'd0, ram_rw},    32'd0);
    chk("t2_if_addr",    ram_addr,           32'h200);
    chk("t2_if_wdata",   ram_wdata,          32'd0);
    cyc();
    chk("t2_if_ack",     {31'd0, if_ack},    32'd1);
    chk("t2_if_rdata",   if_rdata,           32'h200 ^ K);
    if_req = 1'b0;
    cyc();
    chk("t2_idle",       {31'd0, ram_en},    32'd0);

    // 3) starvation limit: four MEM accesses, one IF, then MEM again
    mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'h80; mem_size = 2'b10;
    if_req = 1'b1; if_addr = 32'h300;
    n_m = 0; n_i = 0; m_before = -1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (mem_ack) begin
        n_m++;
        chk("t3_mem_rdata", mem_rdata, 32'h80 ^ K);
      end
      if (if_ack) begin
        n_i++;
        if (m_before < 0) m_before = n_m;
        chk("t3_if_rdata", if_rdata, 32'h300 ^ K);
        if_req = 1'b0;
      end
    end
    chk("t3_mem_before_if", m_before, 32'd4);
    chk("t3_if_acks",       n_i,      32'd1);
    chk("t3_mem_acks",      n_m,      32'd5);
    mem_req = 1'b0; if_req = 1'b0;
    cyc();

    // 4) flush in the first IF_BUSY cycle hands the port to MEM
    if_req = 1'b1; if_addr = 32'h400;
    cyc();
    chk("t4_if_busy_addr", ram_addr, 32'h400);
    if_flush = 1'b1; mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'h84;
    #1;
    chk("t4_flush_no_ack", {31'd0, if_ack},   32'd0);
    chk("t4_flush_stall",  {31'd0, if_stall}, 32'd1);
    cyc();
    if_flush = 1'b0;
    #1;
    chk("t4_mem_addr",     ram_addr,          32'h84);
    chk("t4_if_ack_0",     {31'd0, if_ack},   32'd0);
    chk("t4_if_stall_1",   {31'd0, if_stall}, 32'd1);
    cyc();
    chk("t4_mem_ack",      {31'd0, mem_ack},  32'd1);
    chk("t4_mem_rdata",    mem_rdata,         32'h84 ^ K);
    chk("t4_if_stall_2",   {31'd0, if_stall}, 32'd1);
    mem_req = 1'b0;
    cyc();
    chk("t4_if_regrant",   ram_addr,          32'h400);
    cyc();
    chk("t4_if_ack",       {31'd0, if_ack},   32'd1);
    if_req = 1'b0;
    cyc();

    // 5) async reset mid MEM_BUSY discards the access
    mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h88; mem_wdata = 32'h1234_5678;
    cyc();
    chk("t5_busy_en", {31'd0, ram_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_en",    {31'd0, ram_en},  32'd0);
    chk("t5_rst_ack",   {31'd0, mem_ack}, 32'd0);
    chk("t5_rst_addr",  ram_addr,         32'd0);
    mem_req = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_post_en",  {31'd0, ram_en},  32'd0);
      chk("t5_post_ack", {31'd0, mem_ack}, 32'd0);
    end

    // 6) zero wait states: one fetch per cycle
    b_if_req = 1'b1; b_if_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_if_ack",   {31'd0, b_if_ack}, 32'd1);
      chk("t6_ram_addr", b_ram_addr,        32'(4 * i));
      chk("t6_if_rdata", b_if_rdata,        32'(4 * i) ^ K);
      b_if_addr = 32'(4 * (i + 1));
    end
    b_if_req = 1'b0;
    cyc();
    chk("t6_idle", {31'd0, b_ram_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
